voter_session_ctrl: RTL

//  Sequences one voting session for 4 voters: opens a ballot window, latches each

---
 rtl/voter_pkg.sv | 31 +++
 rtl/voter_if.sv | 23 ++
 rtl/voter_session_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/voter_pkg.sv
// voter_pkg: shared definitions for the voter session controller.
//   state_t   - session FSM encoding (IDLE -> OPEN -> EVAL -> HOLD)
//   RES_*     - one-hot verdict codes presented on result[2:0]
//   N_VOTERS  - number of voters on the ballot
//   yes_count - number of yes votes in a ballot
package voter_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_EVAL = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [2:0] RES_FAIL = 3'b100;
  localparam logic [2:0] RES_TIE  = 3'b010;
  localparam logic [2:0] RES_PASS = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  function automatic logic [2:0] yes_count(input logic [N_VOTERS-1:0] ballot);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < N_VOTERS; i++) begin
      cnt = cnt + 3'(ballot[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/voter_if.sv
// voter_if: combinational 4-voter decoder.
//   I  in  N_VOTERS  locked ballot, bit i = voter i voted yes
//   O  out 3         one-hot verdict: 0-1 yes = fail, 2 yes = tie, 3-4 yes = pass
module voter_if
  import voter_pkg::*;
(
  input  logic [N_VOTERS-1:0] I,
  output logic [2:0]          O
);

  logic [2:0] yes;

  always_comb begin
    yes = yes_count(I);
    O   = RES_FAIL;
    if (yes == 3'd2) begin
      O = RES_TIE;
    end else if (yes >= 3'd3) begin
      O = RES_PASS;
    end
  end

endmodule

// File: rtl/voter_session_ctrl.sv
// voter_session_ctrl: runs one 4-voter ballot session between the push-button
// front end and the result display.
//   clk, rst     clock, synchronous active-high reset
//   start        open a session (only acted on in IDLE)
//   abort        cancel an open session without a result
//   vote_en/val  per-voter vote strobe and value (1 = yes)
//   res_ack      consumer accepts the presented result
//   busy         session open or result pending
//   voted        voters that have cast in the current/last session
//   res_valid    result and timed_out are valid
//   result       one-hot verdict (100 fail, 010 tie, 001 pass)
//   timed_out    window closed by the timer rather than by all-voted
//   session_cnt  number of acknowledged sessions (wraps)
//   state_dbg    current FSM state, for observation only
//
// Result handshake: res_valid rises one cycle after the window closes and then
// holds, with result/timed_out/voted frozen, until res_ack is sampled high; the
// same edge drops res_valid, bumps session_cnt and returns to IDLE.
module voter_session_ctrl
  import voter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TMR_W       = 5,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_VOTERS-1:0] vote_en,
  input  logic [N_VOTERS-1:0] vote_val,
  input  logic                res_ack,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted,
  output logic                res_valid,
  output logic [2:0]          result,
  output logic                timed_out,
  output logic [CNT_W-1:0]    session_cnt,
  output state_t              state_dbg
);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q;
  logic [N_VOTERS-1:0] voted_q, ballot_q;
  logic                res_valid_q, timed_out_q;
  logic [2:0]          result_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [N_VOTERS-1:0] accept;
  logic [N_VOTERS-1:0] voted_nxt;
  logic                all_cast;
  logic                expire;
  logic [2:0]          verdict;

  // Only a voter's first strobe lands; later strobes from that voter are dropped.
  assign accept    = vote_en & ~voted_q;
  assign voted_nxt = voted_q | vote_en;
  // all_cast includes votes landing this cycle, so a last-cycle full ballot
  // closes as all-voted rather than as a timeout.
  assign all_cast  = &voted_nxt;
  assign expire    = (timer_q == TMR_W'(1));

  voter_if u_decode (
    .I (ballot_q),
    .O (verdict)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks closing the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_OPEN;
      S_OPEN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (all_cast || expire) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: state_d = S_HOLD;
      S_HOLD: if (res_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
  end

  // Timer, ballot and registered result path
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q     <= '0;
      voted_q     <= '0;
      ballot_q    <= '0;
      res_valid_q <= 1'b0;
      result_q    <= RES_NONE;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            voted_q     <= '0;
            ballot_q    <= '0;
            timed_out_q <= 1'b0;
            timer_q     <= TMR_W'(TIMEOUT_CYC);
          end
        end
        S_OPEN: begin
          if (abort) begin
            voted_q  <= '0;
            ballot_q <= '0;
          end else begin
            ballot_q <= (ballot_q & ~accept) | (vote_val & accept);
            voted_q  <= voted_nxt;
            timer_q  <= timer_q - TMR_W'(1);
            if (expire && !all_cast) begin
              timed_out_q <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          result_q    <= verdict;
          res_valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (res_ack) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign voted       = voted_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign timed_out   = timed_out_q;
  assign session_cnt = cnt_q;

endmodule
